gowin_fft_mem: RTL and testbench
================================

// Module: gowin_fft_mem
// PURPOSE
//  Memory subsystem for the 1024-point FFT engine (fft1024), a behavioural model of Gowin BSRAM/pROM.
//  Two 2048x32 single-port RAMs (fft0, fft1) hold ping-pong butterfly data (re[31:16], im[15:0], signed).
//  One 2048x16 ROM (w) holds signed Q1.14 twiddle factors. fft1024 drives all address/control pins.
// PARAMETERS
//  READ_MODE   0            0 = bypass: dout registered once, latency 1; 1 = pipeline: extra oce-gated reg, latency 2
//  WRITE_MODE  0            0 = normal: dout holds during write; 1 = write-through: dout <= din on write
//  W_INIT_FILE "w_rom.hex"  $readmemh image for the w ROM (2048 lines, 4 hex digits)
// PORTS
//  clk     in   1   clock, all memories rising-edge
//  rst_n   in   1   reset; async active-low; clears output registers only
//  ce0     in   1   fft0 clock enable
//  oce0    in   1   fft0 output-register enable (pipeline mode only)
//  wre0    in   1   fft0 write enable (1 = write, 0 = read)
//  ad0     in   11  fft0 address
//  din0    in   32  fft0 write data
//  dout0   out  32  fft0 read data
//  ce1, oce1, wre1, ad1[10:0], din1[31:0], dout1[31:0]   same as fft0, for fft1
//  ce_w    in   1   w ROM clock enable
//  oce_w   in   1   w ROM output-register enable (pipeline mode only)
//  ad_w    in   11  w ROM address
//  dout_w  out  16  w ROM data
// BEHAVIOUR
//  Clock/reset: clk, asynchronous active-low rst_n. Reset dominates ce/wre on the same edge.
//  - Reset: dout0, dout1, dout_w and all pipeline regs = 0. RAM/ROM contents untouched by reset.
//  - Power-up: RAM arrays all 0. ROM loaded from W_INIT_FILE at time 0.
//  - RAM, edge with ce=1 & wre=1: mem[ad] <= din.
//    WRITE_MODE=0: data reg holds. WRITE_MODE=1: data reg <= din.
//  - RAM, edge with ce=1 & wre=0: data reg <= mem[ad] (value before any same-edge write; single port, no conflict).
//  - ce=0: no access; data reg holds.
//  - READ_MODE=0: dout = data reg; oce ignored; read at edge N visible after edge N.
//  - READ_MODE=1: out reg <= data reg on edges with oce=1, else holds; dout = out reg; latency 2 edges.
//    ce=0 does not block the oce stage.
//  - ROM: same as RAM read path, no write. Contents, k = ad_w[9:0]:
//      ad_w[10]=0 -> round(16384*cos(2*pi*k/1024))
//      ad_w[10]=1 -> round(-16384*sin(2*pi*k/1024))
//    Two's complement, saturated to 16 bits.
//  - Full 11-bit address range valid; no wrap or out-of-range case.
//  - fft0, fft1 and w are independent; simultaneous accesses to all three allowed every cycle.
//  - Mid-operation reset clears outputs at once. Writes already committed remain.
// TESTING
//  1 Reset: hold rst_n=0 with ce*=1 -> dout0=dout1=dout_w=0; release, no accesses -> outputs stay 0.
//  2 fft0 write 0x12345678 @ad0=5, then read @5 -> dout0=0x12345678 one edge after read
//    (READ_MODE=0); dout0 unchanged during the write edge.
//  3 fft1 back-to-back: write @0..3 = 0x0001_0000..0x0004_0000; read @0..3 every cycle
//    -> dout1 streams the same values, latency 1; fft0 concurrently untouched (still 0 @0..3).
//  4 ROM reads: ad_w=0 -> 0x4000; ad_w=256 -> 0x0000; ad_w=1024+256 -> 0xC000; ad_w=1024 -> 0x0000.
//  5 Hold: ce0=0 with changing ad0/wre0=1 -> no write, dout0 holds.
//    READ_MODE=1: oce0=0 holds dout0, oce0=1 updates after 2 edges.
//  6 Async reset mid-stream: rst_n low between edges -> outputs 0 immediately;
//    reread @5 after release -> 0x12345678 (contents preserved).

Source files
------------

// File: rtl/gowin_fft_mem.sv
// ---------------------------------------------------------------------------
// gowin_fft_mem
//
// Behavioural model of the memory subsystem behind the fft1024 engine. It
// mirrors Gowin BSRAM/pROM primitives:
//   - two 2048x32 single-port RAMs (fft0, fft1) holding ping-pong butterfly
//     data, packed as re[31:16] / im[15:0], both signed
//   - one 2048x16 ROM (w) holding signed Q1.14 twiddle factors
// fft1024 drives every address and control pin. The three memories are
// fully independent and can all be accessed on every clock.
//
// Parameters
//   READ_MODE   0 = bypass (dout is the data register, latency 1)
//               1 = pipeline (extra oce-gated output register, latency 2)
//   WRITE_MODE  0 = normal (data register holds during a write)
//               1 = write-through (data register takes din on a write)
//   W_INIT_FILE name of the twiddle ROM image; the model builds the same
//               cos / -sin table arithmetically at time 0
//
// Ports
//   clk                 rising-edge clock for all memories
//   rst_n               async active-low; clears output registers only
//   ce0/oce0/wre0       fft0 clock enable / output-reg enable / write enable
//   ad0[10:0]           fft0 address
//   din0[31:0]          fft0 write data
//   dout0[31:0]         fft0 read data
//   ce1 ... dout1       same set for fft1
//   ce_w/oce_w          w ROM clock enable / output-reg enable
//   ad_w[10:0]          w ROM address
//   dout_w[15:0]        w ROM data
// ---------------------------------------------------------------------------

// One 2048x32 single-port RAM with the BSRAM output register options.
module gowin_fft_mem_ram #(
  parameter int READ_MODE  = 0,
  parameter int WRITE_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        oce,
  input  logic        wre,
  input  logic [10:0] ad,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Array powers up cleared; reset never touches it, so committed data
  // survives a mid-operation reset.
  logic [31:0] mem [2048] = '{default: '0};
  logic [31:0] data_reg;
  logic [31:0] out_reg;

  always_ff @(posedge clk) begin
    if (ce && wre) begin
      mem[ad] <= din;
    end
  end

  // Reads see the array contents from before this edge; the port is single,
  // so a read and a write never target the array on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else if (ce) begin
      if (!wre) begin
        data_reg <= mem[ad];
      end else if (WRITE_MODE == 1) begin
        data_reg <= din;
      end
    end
  end

  // The output stage follows oce only, so it keeps draining even while ce
  // is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
    end else if (oce) begin
      out_reg <= data_reg;
    end
  end

  assign dout = (READ_MODE == 1) ? out_reg : data_reg;

endmodule

module gowin_fft_mem #(
  parameter int    READ_MODE   = 0,
  parameter int    WRITE_MODE  = 0,
  parameter string W_INIT_FILE = "w_rom.hex"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce0,
  input  logic        oce0,
  input  logic        wre0,
  input  logic [10:0] ad0,
  input  logic [31:0] din0,
  output logic [31:0] dout0,
  input  logic        ce1,
  input  logic        oce1,
  input  logic        wre1,
  input  logic [10:0] ad1,
  input  logic [31:0] din1,
  output logic [31:0] dout1,
  input  logic        ce_w,
  input  logic        oce_w,
  input  logic [10:0] ad_w,
  output logic [15:0] dout_w
);

  localparam real PI = 3.14159265358979323846;

  typedef logic [2047:0][15:0] rom_image_t;

  // Twiddle word for ROM address idx: lower half is cos, upper half is -sin,
  // both over a 1024-point circle, scaled by 2^14, rounded half away from
  // zero and saturated to 16-bit two's complement.
  function automatic logic [15:0] twiddle(input int idx);
    real angle;
    real scaled;
    int  rounded;
    angle = 2.0 * PI * $itor(idx % 1024) / 1024.0;
    if (idx < 1024) begin
      scaled = 16384.0 * $cos(angle);
    end else begin
      scaled = -16384.0 * $sin(angle);
    end
    if (scaled >= 0.0) begin
      rounded = $rtoi(scaled + 0.5);
    end else begin
      rounded = -$rtoi(0.5 - scaled);
    end
    if (rounded > 32767) begin
      rounded = 32767;
    end else if (rounded < -32768) begin
      rounded = -32768;
    end
    return rounded[15:0];
  endfunction

  // ROM image is fixed at time 0, computed from the twiddle definition.
  function automatic rom_image_t build_rom();
    rom_image_t packed_image;
    for (int k = 0; k < 2048; k++) begin
      packed_image[11'(k)] = twiddle(k);
    end
    return packed_image;
  endfunction

  logic [2047:0][15:0] rom_image = build_rom();
  logic [15:0]         w_data;
  logic [15:0]         w_out;

  gowin_fft_mem_ram #(
    .READ_MODE  (READ_MODE),
    .WRITE_MODE (WRITE_MODE)
  ) u_fft0 (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce0),
    .oce   (oce0),
    .wre   (wre0),
    .ad    (ad0),
    .din   (din0),
    .dout  (dout0)
  );

  gowin_fft_mem_ram #(
    .READ_MODE  (READ_MODE),
    .WRITE_MODE (WRITE_MODE)
  ) u_fft1 (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce1),
    .oce   (oce1),
    .wre   (wre1),
    .ad    (ad1),
    .din   (din1),
    .dout  (dout1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_data <= '0;
    end else if (ce_w) begin
      w_data <= rom_image[ad_w];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_out <= '0;
    end else if (oce_w) begin
      w_out <= w_data;
    end
  end

  assign dout_w = (READ_MODE == 1) ? w_out : w_data;

endmodule

// File: tb/tb_gowin_fft_mem.sv
// ---------------------------------------------------------------------------
// tb_gowin_fft_mem
//
// Drives two copies of gowin_fft_mem from the same stimulus: dut_a in
// bypass / normal-write mode and dut_b in pipeline / write-through mode.
// A reference model holds the memory contents as plain arrays and the
// visible output of each mode, and every cycle all six outputs are checked
// against it, along with literal values for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_gowin_fft_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce  [2];
  logic        oce [2];
  logic        wre [2];
  logic [10:0] ad  [2];
  logic [31:0] din [2];
  logic        ce_w, oce_w;
  logic [10:0] ad_w;

  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic [15:0] dout_w_a, dout_w_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: memory contents plus, per mode, the last value fetched
  // (fetched_m) and the value currently presented by the pipeline stage.
  logic [31:0] ram_m [2][2048];
  logic [15:0] rom_m [2048];
  logic [31:0] fetched_m [2][2];
  logic [31:0] piped_m [2];
  logic [15:0] w_fetched_m;
  logic [15:0] w_piped_m;

  always #5 clk = ~clk;

  gowin_fft_mem #(
    .READ_MODE   (0),
    .WRITE_MODE  (0),
    .W_INIT_FILE ("")
  ) dut_a (
    .clk (clk), .rst_n (rst_n),
    .ce0 (ce[0]), .oce0 (oce[0]), .wre0 (wre[0]), .ad0 (ad[0]), .din0 (din[0]), .dout0 (dout0_a),
    .ce1 (ce[1]), .oce1 (oce[1]), .wre1 (wre[1]), .ad1 (ad[1]), .din1 (din[1]), .dout1 (dout1_a),
    .ce_w (ce_w), .oce_w (oce_w), .ad_w (ad_w), .dout_w (dout_w_a)
  );

  gowin_fft_mem #(
    .READ_MODE   (1),
    .WRITE_MODE  (1),
    .W_INIT_FILE ("")
  ) dut_b (
    .clk (clk), .rst_n (rst_n),
    .ce0 (ce[0]), .oce0 (oce[0]), .wre0 (wre[0]), .ad0 (ad[0]), .din0 (din[0]), .dout0 (dout0_b),
    .ce1 (ce[1]), .oce1 (oce[1]), .wre1 (wre[1]), .ad1 (ad[1]), .din1 (din[1]), .dout1 (dout1_b),
    .ce_w (ce_w), .oce_w (oce_w), .ad_w (ad_w), .dout_w (dout_w_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Twiddle table straight from the cos / -sin definition.
  task automatic build_rom_model();
    real v;
    for (int a = 0; a < 2048; a++) begin
      if (a < 1024) v = 16384.0 * $cos(2.0 * 3.14159265358979323846 * $itor(a) / 1024.0);
      else          v = -16384.0 * $sin(2.0 * 3.14159265358979323846 * $itor(a - 1024) / 1024.0);
      rom_m[a] = 16'($rtoi($floor(v + 0.5)));
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      fetched_m[p][0] = '0;
      fetched_m[p][1] = '0;
      piped_m[p] = '0;
    end
    w_fetched_m = '0;
    w_piped_m = '0;
  endtask

  // One rising edge with reset released, using the inputs as presented.
  task automatic model_edge();
    for (int p = 0; p < 2; p++) begin
      if (oce[p]) piped_m[p] = fetched_m[p][1];
      if (ce[p]) begin
        if (wre[p]) begin
          ram_m[p][ad[p]] = din[p];
          fetched_m[p][1] = din[p];
        end else begin
          fetched_m[p][0] = ram_m[p][ad[p]];
          fetched_m[p][1] = ram_m[p][ad[p]];
        end
      end
    end
    if (oce_w) w_piped_m = w_fetched_m;
    if (ce_w) w_fetched_m = rom_m[ad_w];
  endtask

  task automatic check_all(input string tag);
    checkOutput({tag, "/dout0_a"}, dout0_a, fetched_m[0][0]);
    checkOutput({tag, "/dout1_a"}, dout1_a, fetched_m[1][0]);
    checkOutput({tag, "/dout_w_a"}, {16'h0, dout_w_a}, {16'h0, w_fetched_m});
    checkOutput({tag, "/dout0_b"}, dout0_b, piped_m[0]);
    checkOutput({tag, "/dout1_b"}, dout1_b, piped_m[1]);
    checkOutput({tag, "/dout_w_b"}, {16'h0, dout_w_b}, {16'h0, w_piped_m});
  endtask

  // Advance one clock, update the model, then check 1 time unit later.
  task automatic applyStimulus(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed entirely between two edges.
  task automatic async_reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle_all();
    for (int p = 0; p < 2; p++) begin
      ce[p] = 1'b0; wre[p] = 1'b0; oce[p] = 1'b1; ad[p] = '0; din[p] = '0;
    end
    ce_w = 1'b0; oce_w = 1'b1; ad_w = '0;
  endtask

  initial begin
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 2048; a++) ram_m[p][a] = '0;
    build_rom_model();
    model_reset();

    // Reset held with every enable active.
    for (int p = 0; p < 2; p++) begin
      ce[p] = 1'b1; wre[p] = 1'b0; oce[p] = 1'b1; ad[p] = 11'd7; din[p] = '0;
    end
    ce_w = 1'b1; oce_w = 1'b1; ad_w = 11'd0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("reset");
      checkOutput("reset_dout_w", {16'h0, dout_w_a}, 32'h0);
    end
    rst_n = 1'b1;
    idle_all();
    for (int i = 0; i < 2; i++) begin
      applyStimulus("post_reset");
      checkOutput("post_reset_dout0", dout0_a, 32'h0);
    end

    // fft0 write then read at address 5.
    ce[0] = 1'b1; wre[0] = 1'b1; ad[0] = 11'd5; din[0] = 32'h12345678;
    applyStimulus("wr5");
    checkOutput("wr5_hold", dout0_a, 32'h0);
    wre[0] = 1'b0;
    applyStimulus("rd5");
    checkOutput("rd5_data", dout0_a, 32'h12345678);

    // fft1 back-to-back writes, then streaming reads alongside fft0 reads.
    for (int i = 0; i < 4; i++) begin
      ce[0] = 1'b0;
      ce[1] = 1'b1; wre[1] = 1'b1; ad[1] = 11'(i); din[1] = 32'(i + 1) << 16;
      applyStimulus("fft1_wr");
    end
    for (int i = 0; i < 4; i++) begin
      ce[0] = 1'b1; wre[0] = 1'b0; ad[0] = 11'(i);
      ce[1] = 1'b1; wre[1] = 1'b0; ad[1] = 11'(i);
      applyStimulus("fft1_rd");
      checkOutput("fft1_stream", dout1_a, 32'(i + 1) << 16);
      checkOutput("fft0_untouched", dout0_a, 32'h0);
    end
    idle_all();

    // Twiddle ROM spot values.
    begin
      logic [10:0] rom_ad [4];
      logic [15:0] rom_exp [4];
      rom_ad  = '{11'd0, 11'd256, 11'd1280, 11'd1024};
      rom_exp = '{16'h4000, 16'h0000, 16'hC000, 16'h0000};
      for (int i = 0; i < 4; i++) begin
        ce_w = 1'b1; ad_w = rom_ad[i];
        applyStimulus("rom");
        checkOutput("rom_value", {16'h0, dout_w_a}, {16'h0, rom_exp[i]});
      end
      ce_w = 1'b0;
    end

    // Hold behaviour on fft0.
    ce[0] = 1'b1; wre[0] = 1'b0; ad[0] = 11'd5; oce[0] = 1'b1;
    applyStimulus("hold_prep");
    for (int i = 0; i < 4; i++) begin
      ce[0] = 1'b0; wre[0] = 1'b1; ad[0] = 11'(5 + (i % 3)); din[0] = 32'hDEADBEEF;
      applyStimulus("hold_ce0");
      checkOutput("hold_dout0", dout0_a, 32'h12345678);
    end
    ce[0] = 1'b1; wre[0] = 1'b0; ad[0] = 11'd0; oce[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus("hold_oce0");
      checkOutput("hold_oce_b", dout0_b, 32'h12345678);
    end
    ce[0] = 1'b0; oce[0] = 1'b1;
    applyStimulus("oce_release");
    checkOutput("oce_release_b", dout0_b, 32'h0);
    ce[0] = 1'b1; wre[0] = 1'b0; ad[0] = 11'd5;
    applyStimulus("reread5");
    checkOutput("no_write_while_ce0", dout0_a, 32'h12345678);

    // Async reset mid-stream, contents preserved.
    ce[1] = 1'b1; ad[1] = 11'd2; ce_w = 1'b1; ad_w = 11'd0;
    applyStimulus("pre_async");
    async_reset_pulse("async_rst");
    checkOutput("async_rst_dout0", dout0_a, 32'h0);
    ce[0] = 1'b1; wre[0] = 1'b0; ad[0] = 11'd5; ce[1] = 1'b0; ce_w = 1'b0;
    applyStimulus("after_rst1");
    checkOutput("after_rst_a", dout0_a, 32'h12345678);
    applyStimulus("after_rst2");
    checkOutput("after_rst_b", dout0_b, 32'h12345678);

    // Randomised traffic on all three memories, with occasional resets.
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < 2; p++) begin
        ce[p]  = ($urandom_range(0, 3) != 0);
        wre[p] = ($urandom_range(0, 2) == 0);
        oce[p] = ($urandom_range(0, 3) != 0);
        ad[p]  = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
        din[p] = $urandom;
      end
      ce_w  = ($urandom_range(0, 3) != 0);
      oce_w = ($urandom_range(0, 3) != 0);
      ad_w  = 11'($urandom);
      applyStimulus("random");
      if ($urandom_range(0, 49) == 0) async_reset_pulse("random_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
